// File: rtl/dual_lane_capture.sv
// dual_lane_capture: first-word-fall-through FIFO holding {lane1, lane2} pairs between a producer and a stalling consumer.
// Define DUAL_LANE_CAPTURE_PARITY_EN to store an even-parity bit per entry and flag mismatches at the head.
module dual_lane_capture #(
    parameter int WIDTH1     = 2,
    parameter int WIDTH2     = 4,
    parameter int DEPTH_LOG2 = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [WIDTH1-1:0]     in_lane1,
    input  logic [WIDTH2-1:0]     in_lane2,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [WIDTH1-1:0]     out_lane1,
    output logic [WIDTH2-1:0]     out_lane2,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  parity_err
);

    localparam int DEPTH = 2 ** DEPTH_LOG2;
    localparam int PW    = DEPTH_LOG2 + 1;

    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]         count_q, count_d;
    logic [WIDTH1-1:0]     lane1_mem_q [DEPTH];
    logic [WIDTH2-1:0]     lane2_mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_addr, rd_addr;
    logic                  full, empty, push, pop;

    assign wr_addr = wr_ptr_q[DEPTH_LOG2-1:0];
    assign rd_addr = rd_ptr_q[DEPTH_LOG2-1:0];

    // Wrap bit distinguishes full from empty when the addresses coincide.
    assign empty = (rd_ptr_q == wr_ptr_q);
    assign full  = (rd_addr == wr_addr) && (rd_ptr_q[DEPTH_LOG2] != wr_ptr_q[DEPTH_LOG2]);

    assign in_ready  = !full;
    assign out_valid = !empty;
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    assign out_lane1 = lane1_mem_q[rd_addr];
    assign out_lane2 = lane2_mem_q[rd_addr];
    assign count     = count_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q + PW'(push);
        rd_ptr_d = rd_ptr_q + PW'(pop);
        count_d  = count_q + PW'(push) - PW'(pop);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is deliberately left out of reset; out_valid masks stale contents.
    always_ff @(posedge clk) begin
        if (push) begin
            lane1_mem_q[wr_addr] <= in_lane1;
            lane2_mem_q[wr_addr] <= in_lane2;
        end
    end

`ifdef DUAL_LANE_CAPTURE_PARITY_EN
    logic par_mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (push) begin
            par_mem_q[wr_addr] <= ^{in_lane2, in_lane1};
        end
    end

    assign parity_err = out_valid & ((^{out_lane2, out_lane1}) != par_mem_q[rd_addr]);
`else
    assign parity_err = 1'b0;
`endif

endmodule
